// File: rtl/ks0108_pkg.sv
// ks0108_pkg: shared constants for the KS0108 bus responder.
//   - Instruction match values/masks for the four legal instruction classes.
//   - Framebuffer geometry (PAGES x COLS bytes per chip).
//   - FSM state encoding and a small decode helper.
package ks0108_pkg;

  localparam int unsigned PAGES = 8;
  localparam int unsigned COLS  = 64;

  localparam logic [7:0] DISP_ONOFF_VAL  = 8'h3E;
  localparam logic [7:0] DISP_ONOFF_MASK = 8'hFE;
  localparam logic [7:0] SET_Y_VAL       = 8'h40;
  localparam logic [7:0] SET_Y_MASK      = 8'hC0;
  localparam logic [7:0] SET_X_VAL       = 8'hB8;
  localparam logic [7:0] SET_X_MASK      = 8'hF8;
  localparam logic [7:0] START_LINE_VAL  = 8'hC0;
  localparam logic [7:0] START_LINE_MASK = 8'hC0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_WRITE0 = 2'd2;
  localparam logic [1:0] ST_WRITE1 = 2'd3;

  // One captured bus transaction; sel[k] = chip k selected.
  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic [1:0] sel;
  } txn_t;

  function automatic logic op_match(input logic [7:0] d, input logic [7:0] val,
                                    input logic [7:0] mask);
    return (d & mask) == val;
  endfunction

  // First write state for a transaction; sel is never zero here.
  function automatic logic [1:0] first_state(input logic [1:0] sel);
    return sel[0] ? ST_WRITE0 : ST_WRITE1;
  endfunction

endpackage

// File: rtl/ks0108_bus_responder_lcd_in_sync.sv
// lcd_in_sync: multi-stage synchronizer for all LCD bus inputs plus an
// EN falling-edge detector.
//   clk, reset            : system clock, async active-high reset
//   data, en, rs, cs_1/2  : raw LCD bus inputs
//   reset_n               : raw LCD reset (active low)
//   *_s                   : synchronized copies (all from the same stage)
//   strobe                : one-cycle pulse on falling edge of synchronized EN
module lcd_in_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       en,
  input  logic       rs,
  input  logic       cs_1,
  input  logic       cs_2,
  input  logic       reset_n,
  output logic [7:0] data_s,
  output logic       rs_s,
  output logic       cs_1_s,
  output logic       cs_2_s,
  output logic       reset_n_s,
  output logic       strobe
);

  logic [12:0] chain_q [STAGES];
  logic        en_s;
  logic        en_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) chain_q[i] <= '0;
      en_prev_q <= 1'b0;
    end else begin
      chain_q[0] <= {en, rs, cs_1, cs_2, reset_n, data};
      for (int i = 1; i < int'(STAGES); i++) chain_q[i] <= chain_q[i-1];
      en_prev_q <= en_s;
    end
  end

  assign {en_s, rs_s, cs_1_s, cs_2_s, reset_n_s, data_s} = chain_q[STAGES-1];
  assign strobe = en_prev_q & ~en_s;

endmodule

// File: rtl/ks0108_bus_responder.sv
// ks0108_bus_responder: passive responder for a dual-chip KS0108 LCD bus.
// Decodes instructions/data writes into a 2x8x64 shadow framebuffer and
// per-chip display state, emits a write-event stream and a readback port.
//   clk, reset          : system clock, async active-high reset
//   lcd_*               : LCD bus inputs (asynchronous to clk)
//   disp_on, start_line : per-chip display state
//   ev_*                : one-cycle event per framebuffer write
//   rd_* / rd_data      : synchronous readback, 1-cycle latency
//   err_count           : saturating protocol-error count
// Optional: define KS0108_BUSY_CHECK_EN to count strobes that hit a chip
// still busy from a previous transaction (BUSY_CYCLES clk cycles).
module ks0108_bus_responder
  import ks0108_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          CS_ACTIVE_HIGH = 1'b1,
  parameter int unsigned BUSY_CYCLES    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lcd_data,
  input  logic        lcd_en_op,
  input  logic        lcd_reg_sel,
  input  logic        lcd_cs_1,
  input  logic        lcd_cs_2,
  input  logic        lcd_reset_n,
  output logic [1:0]  disp_on,
  output logic [11:0] start_line,
  output logic        ev_valid,
  output logic        ev_chip,
  output logic [2:0]  ev_page,
  output logic [5:0]  ev_col,
  output logic [7:0]  ev_data,
  input  logic        rd_chip,
  input  logic [2:0]  rd_page,
  input  logic [5:0]  rd_col,
  output logic [7:0]  rd_data,
  output logic [7:0]  err_count
);

  localparam int unsigned FB_DEPTH = 2 * PAGES * COLS;

  logic [7:0] s_data;
  logic       s_rs, s_cs1, s_cs2, s_reset_n, strobe;

  lcd_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .data      (lcd_data),
    .en        (lcd_en_op),
    .rs        (lcd_reg_sel),
    .cs_1      (lcd_cs_1),
    .cs_2      (lcd_cs_2),
    .reset_n   (lcd_reset_n),
    .data_s    (s_data),
    .rs_s      (s_rs),
    .cs_1_s    (s_cs1),
    .cs_2_s    (s_cs2),
    .reset_n_s (s_reset_n),
    .strobe    (strobe)
  );

  txn_t bus_txn;
  assign bus_txn = {s_data, s_rs, (s_cs2 == CS_ACTIVE_HIGH), (s_cs1 == CS_ACTIVE_HIGH)};

  // Strobes with no chip selected, or during LCD reset, are simply ignored.
  logic strobe_ok;
  assign strobe_ok = strobe && s_reset_n && (bus_txn.sel != 2'b00);

  logic [1:0]      state_q, state_d;
  txn_t            cur_q, cur_d, q_q, q_d;
  logic            q_valid_q, q_valid_d;
  logic [1:0][2:0] x_q, x_d;
  logic [1:0][5:0] y_q, y_d;
  logic [1:0]      disp_q, disp_d;
  logic [1:0][5:0] line_q, line_d;
  logic [7:0]      err_q, err_d;

  logic       wchip, active, done, accept;
  logic       inc_invalid, inc_drop, inc_busy;
  logic       fb_we;
  logic [9:0] fb_waddr;
  logic [8:0] err_sum;

  assign wchip    = (state_q == ST_WRITE1);
  assign active   = s_reset_n && (state_q == ST_WRITE0 || state_q == ST_WRITE1);
  // Last write state of the current transaction, or nothing in flight.
  assign done     = (state_q == ST_IDLE) || (state_q == ST_WRITE1) ||
                    (state_q == ST_WRITE0 && !cur_q.sel[1]);
  assign fb_waddr = {wchip, x_q[wchip], y_q[wchip]};

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    q_d         = q_q;
    q_valid_d   = q_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    disp_d      = disp_q;
    line_d      = line_q;
    fb_we       = 1'b0;
    inc_invalid = 1'b0;
    inc_drop    = 1'b0;
    accept      = 1'b0;

    // Apply the current transaction to the chip of this write state.
    if (active) begin
      if (cur_q.rs) begin
        fb_we        = 1'b1;
        y_d[wchip]   = y_q[wchip] + 6'd1;
      end else if (op_match(cur_q.data, DISP_ONOFF_VAL, DISP_ONOFF_MASK)) begin
        disp_d[wchip] = cur_q.data[0];
      end else if (op_match(cur_q.data, SET_Y_VAL, SET_Y_MASK)) begin
        y_d[wchip] = cur_q.data[5:0];
      end else if (op_match(cur_q.data, SET_X_VAL, SET_X_MASK)) begin
        x_d[wchip] = cur_q.data[2:0];
      end else if (op_match(cur_q.data, START_LINE_VAL, START_LINE_MASK)) begin
        line_d[wchip] = cur_q.data[5:0];
      end else begin
        inc_invalid = 1'b1;
      end
    end

    if (state_q == ST_DECODE) begin
      cur_d     = q_q;
      q_valid_d = 1'b0;
      state_d   = first_state(q_q.sel);
    end else if (done) begin
      state_d = q_valid_q ? ST_DECODE : ST_IDLE;
    end else begin
      state_d = ST_WRITE1;
    end

    // A strobe starts directly when nothing is pending; otherwise it waits
    // in the 1-deep queue (freed during DECODE) or is dropped.
    if (strobe_ok) begin
      if (done && !q_valid_q) begin
        cur_d   = bus_txn;
        state_d = first_state(bus_txn.sel);
        accept  = 1'b1;
      end else if (!q_valid_q || state_q == ST_DECODE) begin
        q_d       = bus_txn;
        q_valid_d = 1'b1;
        accept    = 1'b1;
      end else begin
        inc_drop = 1'b1;
      end
    end

    if (!s_reset_n) begin
      state_d   = ST_IDLE;
      q_valid_d = 1'b0;
      x_d       = '0;
      y_d       = '0;
      disp_d    = '0;
      line_d    = '0;
    end
  end

  assign err_sum = {1'b0, err_q} + {8'b0, inc_invalid} + {8'b0, inc_drop} + {8'b0, inc_busy};
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

`ifdef KS0108_BUSY_CHECK_EN
  logic [1:0][15:0] busy_q;
  logic [1:0]       busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!s_reset_n)                 busy_q[k] <= '0;
        else if (accept && bus_txn.sel[k]) busy_q[k] <= 16'(BUSY_CYCLES);
        else if (busy_q[k] != '0)       busy_q[k] <= busy_q[k] - 16'd1;
      end
    end
  end

  assign busy[0]  = (busy_q[0] != '0);
  assign busy[1]  = (busy_q[1] != '0);
  assign inc_busy = accept && ((bus_txn.sel & busy) != 2'b00);
`else
  logic unused_busy;
  assign unused_busy = accept ^ (BUSY_CYCLES != 32'd0);
  assign inc_busy    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      disp_q    <= '0;
      line_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      disp_q    <= disp_d;
      line_q    <= line_d;
      err_q     <= err_d;
    end
  end

  // Framebuffer contents survive both resets; writes only occur in write states.
  logic [7:0] fb_mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (fb_we) fb_mem[fb_waddr] <= cur_q.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= fb_mem[{rd_chip, rd_page, rd_col}];
  end

  assign ev_valid   = active && cur_q.rs;
  assign ev_chip    = ev_valid & wchip;
  assign ev_page    = ev_valid ? x_q[wchip] : 3'd0;
  assign ev_col     = ev_valid ? y_q[wchip] : 6'd0;
  assign ev_data    = ev_valid ? cur_q.data : 8'd0;
  assign disp_on    = disp_q;
  assign start_line = {line_q[1], line_q[0]};
  assign err_count  = err_q;

endmodule

// File: tb/tb_ks0108_bus_responder.sv
module tb_ks0108_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  lcd_data;
  logic        lcd_en_op, lcd_reg_sel, lcd_cs_1, lcd_cs_2, lcd_reset_n;
  logic [1:0]  disp_on;
  logic [11:0] start_line;
  logic        ev_valid, ev_chip;
  logic [2:0]  ev_page;
  logic [5:0]  ev_col;
  logic [7:0]  ev_data;
  logic        rd_chip;
  logic [2:0]  rd_page;
  logic [5:0]  rd_col;
  logic [7:0]  rd_data;
  logic [7:0]  err_count;

  ks0108_bus_responder dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_data    (lcd_data),
    .lcd_en_op   (lcd_en_op),
    .lcd_reg_sel (lcd_reg_sel),
    .lcd_cs_1    (lcd_cs_1),
    .lcd_cs_2    (lcd_cs_2),
    .lcd_reset_n (lcd_reset_n),
    .disp_on     (disp_on),
    .start_line  (start_line),
    .ev_valid    (ev_valid),
    .ev_chip     (ev_chip),
    .ev_page     (ev_page),
    .ev_col      (ev_col),
    .ev_data     (ev_data),
    .rd_chip     (rd_chip),
    .rd_page     (rd_page),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef KS0108_BUSY_CHECK_EN
  localparam int BUSY_ERR = 1;
`else
  localparam int BUSY_ERR = 0;
`endif

  // Event log: {chip, page, col, data} and the cycle it was seen.
  logic [17:0] evq [$];
  int          evc [$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (ev_valid === 1'b1) begin
      evq.push_back({ev_chip, ev_page, ev_col, ev_data});
      evc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic rs, input logic [7:0] d, input logic c1, input logic c2);
    lcd_cs_1 = c1; lcd_cs_2 = c2; lcd_reg_sel = rs; lcd_data = d;
    tick(3);
    lcd_en_op = 1'b1;
    tick(4);
    lcd_en_op = 1'b0;
    tick(6);
  endtask

  task automatic expect_ev(input string tag, input logic c, input logic [2:0] p,
                           input logic [5:0] col, input logic [7:0] d);
    logic [17:0] got;
    got = '1;
    if (evq.size() != 0) begin
      got = evq.pop_front();
      void'(evc.pop_front());
    end
    check(tag, 32'(got), 32'({c, p, col, d}));
  endtask

  task automatic rd_check(input string tag, input logic c, input logic [2:0] p,
                          input logic [5:0] col, input logic [7:0] exp);
    rd_chip = c; rd_page = p; rd_col = col;
    tick(1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int err0;
    reset = 1'b1; lcd_data = 8'h00; lcd_en_op = 1'b0; lcd_reg_sel = 1'b0;
    lcd_cs_1 = 1'b0; lcd_cs_2 = 1'b0; lcd_reset_n = 1'b0;
    rd_chip = 1'b0; rd_page = 3'd0; rd_col = 6'd0;
    tick(3);
    check("rst_disp_on", 32'(disp_on), 32'd0);
    check("rst_start_line", 32'(start_line), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    lcd_reset_n = 1'b1;
    tick(5);

    // Display on, chip0 only.
    xfer(1'b0, 8'h3F, 1'b1, 1'b0);
    check("disp_on_c0", 32'(disp_on), 32'd1);
    check("err_after_disp", 32'(err_count), 32'd0);

    // X=3, Y=62, three data bytes across the Y wrap.
    xfer(1'b0, 8'hBB, 1'b1, 1'b0);
    xfer(1'b0, 8'h7E, 1'b1, 1'b0);
    xfer(1'b1, 8'hAA, 1'b1, 1'b0);
    xfer(1'b1, 8'h55, 1'b1, 1'b0);
    xfer(1'b1, 8'h0F, 1'b1, 1'b0);
    check("ev_count_3", 32'(evq.size()), 32'd3);
    expect_ev("ev_aa", 1'b0, 3'd3, 6'd62, 8'hAA);
    expect_ev("ev_55", 1'b0, 3'd3, 6'd63, 8'h55);
    expect_ev("ev_0f_wrap", 1'b0, 3'd3, 6'd0, 8'h0F);
    rd_check("rd_0_3_63", 1'b0, 3'd3, 6'd63, 8'h55);
    rd_check("rd_0_3_62", 1'b0, 3'd3, 6'd62, 8'hAA);
    rd_check("rd_0_3_0", 1'b0, 3'd3, 6'd0, 8'h0F);

    // Both chips: start line 5, X=2, Y=10, data 0x81.
    xfer(1'b0, 8'hC5, 1'b1, 1'b1);
    check("start_line_both", 32'(start_line), 32'h145);
    xfer(1'b0, 8'hBA, 1'b1, 1'b1);
    xfer(1'b0, 8'h4A, 1'b1, 1'b1);
    xfer(1'b1, 8'h81, 1'b1, 1'b1);
    check("ev_count_both", 32'(evq.size()), 32'd2);
    if (evc.size() == 2) check("ev_both_consecutive", 32'(evc[1] - evc[0]), 32'd1);
    expect_ev("ev_both_c0", 1'b0, 3'd2, 6'd10, 8'h81);
    expect_ev("ev_both_c1", 1'b1, 3'd2, 6'd10, 8'h81);
    rd_check("rd_1_2_10", 1'b1, 3'd2, 6'd10, 8'h81);

    // Neither chip selected, then an illegal instruction.
    xfer(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ev_none_sel", 32'(evq.size()), 32'd0);
    check("err_none_sel", 32'(err_count), 32'd0);
    xfer(1'b0, 8'h12, 1'b1, 1'b0);
    check("err_bad_instr", 32'(err_count), 32'd1);

    // Back-to-back data strobes 2 clk apart to both chips (Y starts at 11).
    err0 = int'(err_count);
    lcd_cs_1 = 1'b1; lcd_cs_2 = 1'b1; lcd_reg_sel = 1'b1; lcd_data = 8'h11;
    tick(3);
    lcd_en_op = 1'b1; tick(1); lcd_en_op = 1'b0; tick(1);
    lcd_data = 8'h22;
    lcd_en_op = 1'b1; tick(1); lcd_en_op = 1'b0; tick(1);
    lcd_data = 8'h33;
    lcd_en_op = 1'b1; tick(1); lcd_en_op = 1'b0; tick(10);
    check("ev_count_b2b", 32'(evq.size()), 32'd6);
    if (evc.size() == 6) check("ev_b2b_consecutive", 32'(evc[5] - evc[0]), 32'd5);
    expect_ev("ev_b2b_0", 1'b0, 3'd2, 6'd11, 8'h11);
    expect_ev("ev_b2b_1", 1'b1, 3'd2, 6'd11, 8'h11);
    expect_ev("ev_b2b_2", 1'b0, 3'd2, 6'd12, 8'h22);
    expect_ev("ev_b2b_3", 1'b1, 3'd2, 6'd12, 8'h22);
    expect_ev("ev_b2b_4", 1'b0, 3'd2, 6'd13, 8'h33);
    expect_ev("ev_b2b_5", 1'b1, 3'd2, 6'd13, 8'h33);
    check("err_b2b", 32'(int'(err_count) - err0), 32'(2 * BUSY_ERR));

    // LCD reset pulse: state cleared, strobes ignored, framebuffer kept.
    lcd_reset_n = 1'b0;
    tick(6);
    check("lrst_disp_on", 32'(disp_on), 32'd0);
    check("lrst_start_line", 32'(start_line), 32'd0);
    xfer(1'b1, 8'hEE, 1'b1, 1'b0);
    check("lrst_ev_ignored", 32'(evq.size()), 32'd0);
    lcd_reset_n = 1'b1;
    tick(5);
    xfer(1'b1, 8'h5A, 1'b1, 1'b0);
    expect_ev("ev_after_lrst", 1'b0, 3'd0, 6'd0, 8'h5A);
    rd_check("rd_kept_c0", 1'b0, 3'd3, 6'd63, 8'h55);
    rd_check("rd_kept_c1", 1'b1, 3'd2, 6'd10, 8'h81);

    // Two strobes 4 clk apart to chip0: Y=5 then data 0x77.
    err0 = int'(err_count);
    lcd_cs_1 = 1'b1; lcd_cs_2 = 1'b0; lcd_reg_sel = 1'b0; lcd_data = 8'h45;
    tick(3);
    lcd_en_op = 1'b1; tick(2); lcd_en_op = 1'b0; tick(2);
    lcd_reg_sel = 1'b1; lcd_data = 8'h77;
    lcd_en_op = 1'b1; tick(2); lcd_en_op = 1'b0; tick(10);
    expect_ev("ev_busy_pair", 1'b0, 3'd0, 6'd5, 8'h77);
    check("err_busy_pair", 32'(int'(err_count) - err0), 32'(BUSY_ERR));

    // Saturation of err_count.
    for (int i = 0; i < 260; i++) xfer(1'b0, 8'h12, 1'b1, 1'b0);
    check("err_saturate", 32'(err_count), 32'd255);
    check("ev_none_left", 32'(evq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
